// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants and helpers used by the fetch stage.
package arm_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // PC value loaded on reset.
    localparam word_t RESET_PC  = 32'h0000_0000;
    // Instruction placed in IF/ID on flush or reset.
    localparam word_t NOP_INSTR = 32'h0000_0000;
    // Sequential fetch increment (one 32-bit instruction).
    localparam word_t PC_STEP   = 32'h0000_0004;

    // Force a byte address onto a word boundary; the low two bits are dropped.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus plus IF/ID pipeline register outputs of the fetch stage.
// master: fetch stage side; slave: instruction memory / decode side.
interface fetch_stage_if;
    import arm_pkg::*;

    word_t imem_addr;
    word_t imem_instr;
    word_t id_pc;
    word_t id_instr;
    logic  id_valid;

    modport master (
        output imem_addr,
        input  imem_instr,
        output id_pc,
        output id_instr,
        output id_valid
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  id_pc,
        input  id_instr,
        input  id_valid
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with its next-PC mux.
// Priority: load (branch redirect) > hold (freeze) > sequential advance.
// The advance wraps modulo 2^WORD_W without any flag.
module pc_reg
    import arm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold,
    input  logic  load,
    input  word_t target,
    output word_t pc
);

    word_t pc_d;
    word_t pc_q;

    // Next-PC selection: redirect, hold or step to the next word.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = align_word(target);
        end else if (hold) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // PC state register, asynchronously returned to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and captures instruction + PC+4 into IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall counters
// (perf_fetch_cnt, perf_stall_cnt); without it the ports do not exist.
module fetch_stage
    import arm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  word_t                branch_addr,
    fetch_stage_if.master        bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    word_t pc_s;

    word_t id_pc_d;
    word_t id_pc_q;
    word_t id_instr_d;
    word_t id_instr_q;
    logic  id_valid_d;
    logic  id_valid_q;

    // Branch overrides freeze, so the PC only holds on a freeze without redirect.
    pc_reg u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (freeze),
        .load   (branch_taken),
        .target (branch_addr),
        .pc     (pc_s)
    );

    assign bus.imem_addr = pc_s;

    // IF/ID next-state: flush on redirect, hold on freeze, otherwise capture.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;
        if (branch_taken) begin
            id_pc_d    = 32'h0000_0000;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
        end else if (freeze) begin
            id_pc_d    = id_pc_q;
            id_instr_d = id_instr_q;
            id_valid_d = id_valid_q;
        end else begin
            id_pc_d    = pc_s + PC_STEP;
            id_instr_d = bus.imem_instr;
            id_valid_d = 1'b1;
        end
    end

    // IF/ID pipeline register; reset drops in a NOP marked invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_q    <= 32'h0000_0000;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign bus.id_pc    = id_pc_q;
    assign bus.id_instr = id_instr_q;
    assign bus.id_valid = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_d;
    logic [31:0] perf_fetch_cnt_q;
    logic [31:0] perf_stall_cnt_d;
    logic [31:0] perf_stall_cnt_q;

    // Count real captures and pure stalls; both wrap naturally at 2^32.
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (branch_taken) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q;
            perf_stall_cnt_d = perf_stall_cnt_q;
        end else if (freeze) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end else begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt_q <= 32'd0;
            perf_stall_cnt_q <= 32'd0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
    import arm_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  freeze;
    logic  branch_taken;
    word_t branch_addr;

    int n_cmp;
    int n_err;

    fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .bus          (bus.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Instruction memory contents: two fixed words, everything else 0xE0000000|addr.
    function automatic word_t mem_word(input word_t addr);
        if (addr == 32'h0000_0000) return 32'hE3A0_0015;
        if (addr == 32'h0000_0004) return 32'hE3A0_1A01;
        return 32'hE000_0000 | addr;
    endfunction

    assign bus.imem_instr = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input word_t addr, input word_t ins,
                            input word_t pc4, input logic vld);
        check_eq({tag, ".addr"},  bus.imem_addr, addr);
        check_eq({tag, ".instr"}, bus.id_instr, ins);
        check_eq({tag, ".pc"},    bus.id_pc, pc4);
        check_eq({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, vld});
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0000_0000;
        #12;
        check_if("reset", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step();
        check_if("reset_hold", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        rst_n = 1'b1;
        #2;
        check_if("post_rel", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);

        // Sequential fetch
        step(); check_if("seq0", 32'h0000_0004, 32'hE3A0_0015, 32'h0000_0004, 1'b1);
        step(); check_if("seq1", 32'h0000_0008, 32'hE3A0_1A01, 32'h0000_0008, 1'b1);

        // Freeze at PC=8 for three edges
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_if("frz", 32'h0000_0008, 32'hE3A0_1A01, 32'h0000_0008, 1'b1);
        end
        freeze = 1'b0;
        step(); check_if("rel0", 32'h0000_000C, 32'hE000_0008, 32'h0000_000C, 1'b1);
        step(); check_if("rel1", 32'h0000_0010, 32'hE000_000C, 32'h0000_0010, 1'b1);

        // Branch at PC=16 to unaligned 0x1E
        branch_taken = 1'b1; branch_addr = 32'h0000_001E;
        step(); check_if("br", 32'h0000_001C, 32'h0000_0000, 32'h0000_0000, 1'b0);
        branch_taken = 1'b0;
        step(); check_if("br_tgt", 32'h0000_0020, 32'hE000_001C, 32'h0000_0020, 1'b1);

        // Branch and freeze together: branch wins
        branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h0000_0040;
        step(); check_if("br_frz", 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0);
        branch_taken = 1'b0;
        step(); check_if("frz_after_br", 32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 1'b0);
        freeze = 1'b0;
        step(); check_if("after_br_frz", 32'h0000_0044, 32'hE000_0040, 32'h0000_0044, 1'b1);

        // PC wrap at top of address space
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
        step(); check_if("br_top", 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0);
        branch_taken = 1'b0;
        step(); check_if("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        step(); check_if("wrap1", 32'h0000_0004, 32'hE3A0_0015, 32'h0000_0004, 1'b1);

        // Asynchronous reset mid-run, away from any clock edge
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_if("async_rst", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        step(); check_if("rst_edge", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        rst_n = 1'b1;

        // Five fetches, two stalls, one branch
        step(); check_if("rst_f0", 32'h0000_0004, 32'hE3A0_0015, 32'h0000_0004, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check_if("rst_f4", 32'h0000_0014, 32'hE000_0010, 32'h0000_0014, 1'b1);
        freeze = 1'b1;
        step(); step();
        check_if("stall2", 32'h0000_0014, 32'hE000_0010, 32'h0000_0014, 1'b1);
        freeze = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0000_0100;
        step(); check_if("br_end", 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0);
        branch_taken = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetch", perf_fetch_cnt, 32'd5);
        check_eq("perf_stall", perf_stall_cnt, 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        check_eq("perf_stall_rst", perf_stall_cnt, 32'd0);
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the ARM pipeline.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction and PC+4 into the IF/ID pipeline register consumed by decode.
- Handles hazard freeze from the hazard unit and branch redirect/flush from the execute stage.

Parameters:
- WORD_W, 32, width of PC, addresses and instructions.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction placed in IF/ID on flush or reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- freeze  input  1  hazard stall; hold PC and IF/ID.
- branch_taken  input  1  redirect from execute; also flushes IF/ID.
- branch_addr  input  WORD_W  branch target byte address.
- imem_addr  output  WORD_W  byte address to instruction memory (equals PC).
- imem_instr  input  WORD_W  instruction returned combinationally for imem_addr.
- id_pc  output  WORD_W  registered PC+4 of the fetched instruction.
- id_instr  output  WORD_W  registered instruction.
- id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n low, asynchronous): PC=RESET_PC, id_pc=0, id_instr=NOP_INSTR, id_valid=0. Outputs hold these values until the first rising edge after deassertion.
- imem_addr = PC, purely combinational. Instruction memory returns the word in the same cycle. Fetch latency is 1 clock from PC to IF/ID.
- Each rising edge, evaluated in priority order:
  1. branch_taken=1: PC <= {branch_addr[WORD_W-1:2],2'b00}; id_instr <= NOP_INSTR; id_valid <= 0; id_pc <= 0. Branch overrides freeze.
  2. else freeze=1: PC, id_pc, id_instr and id_valid all hold.
  3. else: PC <= PC+4; id_instr <= imem_instr; id_pc <= PC+4; id_valid <= 1.
- PC+4 is modulo 2^WORD_W: 32'hFFFF_FFFC advances to 32'h0000_0000 with no error flag.
- branch_addr[1:0] is ignored. The PC is always word-aligned.
- Branch penalty: the instruction already in fetch is squashed. The target is fetched the cycle after branch_taken, with a valid IF/ID one cycle later.
- Consecutive freeze cycles hold indefinitely. Release resumes with the held PC refetched, so no instruction is lost or duplicated.
- Reset mid-operation discards everything in flight. The first fetch after release is at RESET_PC.
- Only two state bits matter: PC and id_valid. No other FSM.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32), both reset to 0 asynchronously.
  - perf_fetch_cnt increments on every edge that loads id_valid=1 from imem_instr.
  - perf_stall_cnt increments on every edge where freeze=1 and branch_taken=0.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent, and the stage behaviour is otherwise identical.

Decomposition:
- Shared package arm_pkg holds WORD_W, NOP_INSTR, RESET_PC and the PC_STEP=4 constant; fetch_stage imports these.
- One natural sub-module, pc_reg: the PC register with async reset, hold and load-target, plus its next-PC mux.
- The IF/ID capture logic stays in fetch_stage.

Test Plan:
- Reset then run 4 cycles, memory returning 32'hE3A0_0015 at addr 0 and 32'hE3A0_1A01 at 4 -> imem_addr 0,4,8,12. id_instr E3A00015 with id_pc 4, then E3A01A01 with id_pc 8, id_valid=1 from the first edge.
- freeze high for 3 cycles at PC=8 -> imem_addr stays 8; id_instr/id_pc/id_valid unchanged. After release the next capture is the word at 8 with id_pc=12.
- branch_taken with branch_addr=32'h0000_001E at PC=16 -> next PC=32'h1C; IF/ID becomes NOP with id_valid=0. The following edge captures the word at 0x1C with id_pc=0x20.
- branch_taken and freeze both high, branch_addr=32'h40 -> PC=0x40 and flush occur; freeze is ignored that cycle.
- Force PC=32'hFFFF_FFFC via branch, then run -> next imem_addr=0 and id_pc=0. Drop rst_n mid-run -> outputs reset immediately without a clock edge, and the first post-reset fetch is at RESET_PC.
- With FETCH_PERF_CNT_EN: 5 normal fetches, 2 stalls, 1 branch -> perf_fetch_cnt=5, perf_stall_cnt=2.
